// File: rtl/scores_reader.sv
// scores_reader
//   Loads the saved high score from the SD card. It issues one sector read at
//   SCORES_READ_ADDRESS and captures the first four bytes of the sector as a
//   record: {MAGIC, score_hi, score_lo, xor-checksum}. The block then presents
//   the score with a validity flag, or DEFAULT_SCORE if the record is bad or
//   the card never starts the read.
//
// Ports
//   CLK                 in   system clock, posedge
//   RESET               in   asynchronous active-high reset
//   TO_READ             in   level request from game logic
//   SD_HAS_INITIALIZED  in   SD controller init done
//   SD_IS_READING       in   SD controller busy with a sector read
//   SD_BYTE_VALID       in   one-cycle strobe for SD_BYTE
//   SD_BYTE             in   [7:0] sector byte, in order from byte 0
//   SD_TO_READ          out  read request to the SD controller
//   SD_READ_ADDRESS     out  [31:0] constant sector address
//   SCORES_READ         out  [15:0] loaded score (valid while READ_FINISH)
//   READ_VALID          out  record passed every check
//   READ_FINISH         out  read sequence complete (sticky until reset)
module scores_reader #(
  parameter logic [31:0] SCORES_READ_ADDRESS = 32'h0000_2000,
  parameter logic [7:0]  MAGIC               = 8'h5A,
  parameter logic [15:0] DEFAULT_SCORE       = 16'd0,
  parameter logic [15:0] MAX_SCORE           = 16'd9999,
  parameter logic [23:0] REQ_TIMEOUT         = 24'd5_000_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TO_READ,
  input  logic        SD_HAS_INITIALIZED,
  input  logic        SD_IS_READING,
  input  logic        SD_BYTE_VALID,
  input  logic [7:0]  SD_BYTE,
  output logic        SD_TO_READ,
  output logic [31:0] SD_READ_ADDRESS,
  output logic [15:0] SCORES_READ,
  output logic        READ_VALID,
  output logic        READ_FINISH
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_RECEIVE,
    S_CHECK,
    S_FINISH
  } state_t;

  localparam logic [9:0] CNT_MAX = 10'd512;

  state_t          state_q, state_d;
  logic [9:0]      cnt_q, cnt_d;
  logic [23:0]     timer_q, timer_d;
  logic [3:0][7:0] rec_q, rec_d;
  logic            timeout_q, timeout_d;
  logic            sd_to_read_q, sd_to_read_d;
  logic            finish_q, finish_d;
  logic            valid_q, valid_d;
  logic [15:0]     score_q, score_d;

  logic [15:0]     rec_score;
  logic            rec_ok;

  assign SD_READ_ADDRESS = SCORES_READ_ADDRESS;
  assign SD_TO_READ      = sd_to_read_q;
  assign SCORES_READ     = score_q;
  assign READ_VALID      = valid_q;
  assign READ_FINISH     = finish_q;

  // Record check; only consumed in CHECK, where the record regs are stable.
  assign rec_score = {rec_q[1], rec_q[2]};
  assign rec_ok    = ~timeout_q
                   & (cnt_q >= 10'd4)
                   & (rec_q[0] == MAGIC)
                   & (rec_q[3] == (rec_q[0] ^ rec_q[1] ^ rec_q[2]))
                   & (rec_score <= MAX_SCORE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    rec_d     = rec_q;
    timeout_d = timeout_q;
    finish_d  = finish_q;
    valid_d   = valid_q;
    score_d   = score_q;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        timer_d   = '0;
        timeout_d = 1'b0;
        if (TO_READ && SD_HAS_INITIALIZED && !SD_IS_READING)
          state_d = S_REQUEST;
      end
      S_REQUEST: begin
        // Card starting the read wins over a same-cycle timeout.
        if (SD_IS_READING) begin
          state_d = S_RECEIVE;
        end else if (timer_q == REQ_TIMEOUT - 24'd1) begin
          state_d   = S_CHECK;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      S_RECEIVE: begin
        // A strobe on the cycle SD_IS_READING drops is still taken.
        if (SD_BYTE_VALID) begin
          if (cnt_q < 10'd4)
            rec_d[cnt_q[1:0]] = SD_BYTE;
          if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 10'd1;
        end
        if (!SD_IS_READING)
          state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d  = S_FINISH;
        finish_d = 1'b1;
        valid_d  = rec_ok;
        score_d  = rec_ok ? rec_score : DEFAULT_SCORE;
      end
      S_FINISH: ;
      default: state_d = S_IDLE;
    endcase

    // Registered request: high exactly while the FSM sits in REQUEST.
    sd_to_read_d = (state_d == S_REQUEST);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      rec_q        <= '0;
      timeout_q    <= 1'b0;
      sd_to_read_q <= 1'b0;
      finish_q     <= 1'b0;
      valid_q      <= 1'b0;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      rec_q        <= rec_d;
      timeout_q    <= timeout_d;
      sd_to_read_q <= sd_to_read_d;
      finish_q     <= finish_d;
      valid_q      <= valid_d;
      score_q      <= score_d;
    end
  end

endmodule

// File: tb/tb_scores_reader.sv
// Bench for scores_reader. Stimulus tasks push the expected {score, valid}
// onto a queue; a monitor pops and compares on each READ_FINISH rise.
module tb_scores_reader;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        TO_READ = 1'b0;
  logic        SD_HAS_INITIALIZED = 1'b0;
  logic        SD_IS_READING = 1'b0;
  logic        SD_BYTE_VALID = 1'b0;
  logic [7:0]  SD_BYTE = 8'h00;
  logic        SD_TO_READ;
  logic [31:0] SD_READ_ADDRESS;
  logic [15:0] SCORES_READ;
  logic        READ_VALID;
  logic        READ_FINISH;

  scores_reader #(.REQ_TIMEOUT(24'd16)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .TO_READ            (TO_READ),
    .SD_HAS_INITIALIZED (SD_HAS_INITIALIZED),
    .SD_IS_READING      (SD_IS_READING),
    .SD_BYTE_VALID      (SD_BYTE_VALID),
    .SD_BYTE            (SD_BYTE),
    .SD_TO_READ         (SD_TO_READ),
    .SD_READ_ADDRESS    (SD_READ_ADDRESS),
    .SCORES_READ        (SCORES_READ),
    .READ_VALID         (READ_VALID),
    .READ_FINISH        (READ_FINISH)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];   // {valid, score}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the outcome on every READ_FINISH rising edge.
  logic fin_prev = 1'b0;
  always @(negedge CLK) begin
    if (READ_FINISH && !fin_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got finish with score %0h valid %0b expected none",
                 SCORES_READ, READ_VALID);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("sb_score", {16'h0, SCORES_READ}, {16'h0, e[15:0]});
        check("sb_valid", {31'h0, READ_VALID}, {31'h0, e[16]});
      end
    end
    fin_prev = READ_FINISH;
  end

  // Async reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    check("rst_to_read", {31'h0, SD_TO_READ},  32'h0);
    check("rst_finish",  {31'h0, READ_FINISH}, 32'h0);
    check("rst_valid",   {31'h0, READ_VALID},  32'h0);
    check("rst_score",   {16'h0, SCORES_READ}, 32'h0);
    TO_READ = 1'b0; SD_IS_READING = 1'b0; SD_BYTE_VALID = 1'b0; SD_BYTE = 8'h00;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (SD_TO_READ) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_timeout: got SD_TO_READ 0 expected 1 within 20 cycles");
    end
  endtask

  // One full read: n record bytes (from b0..b3) followed by pad zero bytes.
  task automatic run_read(input logic [7:0] b0, b1, b2, b3, input int n, input int pad,
                          input bit fall_with_last, input bit stray,
                          input logic [15:0] exp_score, input logic exp_valid);
    logic [7:0] rec [4];
    bit ok;
    int total;
    rec[0] = b0; rec[1] = b1; rec[2] = b2; rec[3] = b3;
    total = n + pad;
    exp_q.push_back({exp_valid, exp_score});
    SD_HAS_INITIALIZED = 1'b1;
    TO_READ = 1'b1;
    wait_req(ok);
    if (!ok) return;
    SD_IS_READING = 1'b1;
    if (stray) begin
      // Strobe while still in REQUEST; must not land in the record.
      SD_BYTE_VALID = 1'b1; SD_BYTE = 8'hA5;
    end
    @(negedge CLK);
    check("req_fall", {31'h0, SD_TO_READ}, 32'h0);
    SD_BYTE_VALID = 1'b0;
    TO_READ = 1'b0;   // dropping the request must not abort the read
    for (int i = 0; i < total; i++) begin
      SD_BYTE_VALID = 1'b1;
      SD_BYTE = (i < n) ? rec[i] : 8'h00;
      if (fall_with_last && i == total - 1) SD_IS_READING = 1'b0;
      @(negedge CLK);
    end
    SD_BYTE_VALID = 1'b0;
    if (!fall_with_last) begin
      SD_IS_READING = 1'b0;
      @(negedge CLK);
    end
    check("fin_early", {31'h0, READ_FINISH}, 32'h0);
    @(negedge CLK);
    check("fin_latency", {31'h0, READ_FINISH}, 32'h1);
    repeat (2) @(negedge CLK);
    check("fin_sticky", {31'h0, READ_FINISH}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit ok;
    RESET = 1'b1;
    #12 RESET = 1'b0;
    do_reset();
    check("address", SD_READ_ADDRESS, 32'h0000_2000);

    // Idle with init but no request; strobes in IDLE are ignored.
    SD_HAS_INITIALIZED = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      SD_BYTE_VALID = 1'b1; SD_BYTE = 8'hFF;
      @(negedge CLK);
      if (SD_TO_READ) cnt++;
    end
    SD_BYTE_VALID = 1'b0;
    check("idle_no_req", cnt, 0);

    // Good record + 508 pad bytes; checksum 5A^12^34 = 7C.
    run_read(8'h5A, 8'h12, 8'h34, 8'h7C, 4, 508, 1'b0, 1'b0, 16'h1234, 1'b1);
    do_reset();
    run_read(8'h5A, 8'h12, 8'h34, 8'h00, 4, 4, 1'b0, 1'b0, 16'h0000, 1'b0);  // bad checksum
    do_reset();
    run_read(8'hA5, 8'h12, 8'h34, 8'h83, 4, 0, 1'b0, 1'b0, 16'h0000, 1'b0);  // bad magic
    do_reset();
    run_read(8'h5A, 8'h27, 8'h10, 8'h6D, 4, 0, 1'b0, 1'b0, 16'h0000, 1'b0);  // 10000 > max
    do_reset();
    run_read(8'h5A, 8'h27, 8'h0F, 8'h72, 4, 0, 1'b0, 1'b0, 16'h270F, 1'b1);  // 9999 exactly
    do_reset();

    // Timeout: card never starts; request held for REQ_TIMEOUT cycles.
    exp_q.push_back({1'b0, 16'h0000});
    TO_READ = 1'b1;
    cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (SD_TO_READ) cnt++;
      if (READ_FINISH) begin ok = 1'b1; break; end
    end
    check("tmo_req_cycles", cnt, 16);
    check("tmo_finished", {31'h0, ok}, 32'h1);
    do_reset();

    // Short read: 3 bytes, last strobe on the falling cycle -> invalid.
    run_read(8'h5A, 8'h00, 8'h64, 8'h00, 3, 0, 1'b1, 1'b0, 16'h0000, 1'b0);
    do_reset();
    // Four bytes, last on falling cycle, plus stray strobe in REQUEST -> valid.
    run_read(8'h5A, 8'h00, 8'h64, 8'h3E, 4, 0, 1'b1, 1'b1, 16'h0064, 1'b1);

    // Reset while requesting: SD_TO_READ must drop immediately.
    do_reset();
    TO_READ = 1'b1;
    wait_req(ok);
    do_reset();
    // Reset mid-RECEIVE.
    TO_READ = 1'b1;
    wait_req(ok);
    SD_IS_READING = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      SD_BYTE_VALID = 1'b1; SD_BYTE = 8'h5A;
      @(negedge CLK);
    end
    SD_BYTE_VALID = 1'b0;
    do_reset();
    // No request until the card reports init.
    SD_HAS_INITIALIZED = 1'b0;
    TO_READ = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (SD_TO_READ) cnt++;
    end
    check("no_init_no_req", cnt, 0);
    // 5A^01^F4 = AF, score 500.
    run_read(8'h5A, 8'h01, 8'hF4, 8'hAF, 4, 2, 1'b0, 1'b0, 16'h01F4, 1'b1);

    repeat (3) @(negedge CLK);
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
